// File: rtl/unlock_sequencer.sv
// Ordered key-sequence checker fed by a per-position comparator (one byte per handshake).
// Optional lockout after repeated misses is enabled by defining UNLOCK_SEQ_LOCKOUT_EN.
module unlock_sequencer #(
  parameter int SEQ_LEN        = 19,
  parameter int POS_W          = 5,
  parameter int FAIL_W         = 8,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [SEQ_LEN-1:0] unlock,
  input  logic               key_clear,
  output logic [POS_W-1:0]   pos,
  output logic               match_ok,
  output logic               mismatch,
  output logic               done,
  output logic               locked,
  output logic [FAIL_W-1:0]  fail_cnt
);

  if ((2 ** POS_W) < SEQ_LEN || SEQ_LEN < 1 || MAX_FAILS < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cfg
    $error("unlock_sequencer: inconsistent parameters");
  end

`ifdef UNLOCK_SEQ_LOCKOUT_EN
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DONE = 2'd1, ST_LOCK = 2'd2} state_t;
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_TRIP = FAIL_W'(MAX_FAILS);
  logic [LOCK_W-1:0] lock_cnt_r;
  logic [LOCK_W-1:0] lock_cnt_s;
`else
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DONE = 2'd1} state_t;
`endif

  localparam logic [POS_W-1:0]  LAST_POS = POS_W'(SEQ_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_SAT = {FAIL_W{1'b1}};

  state_t              state_r;
  state_t              state_s;
  logic [POS_W-1:0]    pos_r;
  logic [POS_W-1:0]    pos_s;
  logic [FAIL_W-1:0]   fail_r;
  logic [FAIL_W-1:0]   fail_s;
  logic [FAIL_W-1:0]   fail_inc_s;
  logic                match_ok_r;
  logic                match_ok_s;
  logic                mismatch_r;
  logic                mismatch_s;
  logic                done_r;
  logic                done_s;
  logic                locked_r;
  logic                locked_s;
  logic                ready_s;
  logic                hit_s;

  assign ready_s    = (state_r == ST_RUN) && !key_clear;
  assign hit_s      = unlock[pos_r];
  assign fail_inc_s = (fail_r == FAIL_SAT) ? fail_r : (fail_r + FAIL_W'(1));

  // Next-state and next-output decode
  always_comb begin
    state_s    = state_r;
    pos_s      = pos_r;
    fail_s     = fail_r;
    match_ok_s = 1'b0;
    mismatch_s = 1'b0;
`ifdef UNLOCK_SEQ_LOCKOUT_EN
    lock_cnt_s = lock_cnt_r;
`endif
    case (state_r)
      ST_RUN: begin
        if (key_clear) begin
          pos_s = {POS_W{1'b0}};
        end else if (key_valid) begin
          if (hit_s) begin
            match_ok_s = 1'b1;
            if (pos_r == LAST_POS) begin
              state_s = ST_DONE;
              fail_s  = {FAIL_W{1'b0}};
            end else begin
              pos_s = pos_r + POS_W'(1);
            end
          end else begin
            // The missed byte is dropped, never retried as position 0.
            mismatch_s = 1'b1;
            pos_s      = {POS_W{1'b0}};
            fail_s     = fail_inc_s;
`ifdef UNLOCK_SEQ_LOCKOUT_EN
            if (fail_inc_s == FAIL_TRIP) begin
              state_s    = ST_LOCK;
              lock_cnt_s = LOCK_LOAD;
            end else begin
              state_s = ST_RUN;
            end
`endif
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (key_clear) begin
          state_s = ST_RUN;
          pos_s   = {POS_W{1'b0}};
        end else begin
          state_s = ST_DONE;
        end
      end
`ifdef UNLOCK_SEQ_LOCKOUT_EN
      ST_LOCK: begin
        if (lock_cnt_r == {LOCK_W{1'b0}}) begin
          state_s = ST_RUN;
          fail_s  = {FAIL_W{1'b0}};
          pos_s   = {POS_W{1'b0}};
        end else begin
          lock_cnt_s = lock_cnt_r - LOCK_W'(1);
        end
      end
`endif
      default: begin
        state_s = ST_RUN;
        pos_s   = {POS_W{1'b0}};
      end
    endcase
    done_s = (state_s == ST_DONE);
`ifdef UNLOCK_SEQ_LOCKOUT_EN
    locked_s = (state_s == ST_LOCK);
`else
    locked_s = 1'b0;
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      pos_r      <= {POS_W{1'b0}};
      fail_r     <= {FAIL_W{1'b0}};
      match_ok_r <= 1'b0;
      mismatch_r <= 1'b0;
      done_r     <= 1'b0;
      locked_r   <= 1'b0;
`ifdef UNLOCK_SEQ_LOCKOUT_EN
      lock_cnt_r <= {LOCK_W{1'b0}};
`endif
    end else begin
      state_r    <= state_s;
      pos_r      <= pos_s;
      fail_r     <= fail_s;
      match_ok_r <= match_ok_s;
      mismatch_r <= mismatch_s;
      done_r     <= done_s;
      locked_r   <= locked_s;
`ifdef UNLOCK_SEQ_LOCKOUT_EN
      lock_cnt_r <= lock_cnt_s;
`endif
    end
  end

  assign key_ready = ready_s;
  assign pos       = pos_r;
  assign match_ok  = match_ok_r;
  assign mismatch  = mismatch_r;
  assign done      = done_r;
  assign locked    = locked_r;
  assign fail_cnt  = fail_r;

endmodule

// File: tb/tb_unlock_sequencer.sv
// Bench for unlock_sequencer: a comparator model drives unlock from key bytes and a
// sequence-level model is checked every cycle; UNLOCK_SEQ_LOCKOUT_EN selects lockout tests.
module tb_unlock_sequencer;

  localparam int SEQ_LEN  = 19;
  localparam int MAX_F    = 3;
  localparam int LOCK_CYC = 16;
`ifdef UNLOCK_SEQ_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               key_valid;
  logic               key_ready;
  logic [SEQ_LEN-1:0] unlock;
  logic               key_clear;
  logic [4:0]         pos;
  logic               match_ok;
  logic               mismatch;
  logic               done;
  logic               locked;
  logic [7:0]         fail_cnt;

  string pw = "S4t_s01veR_i5_Gr9a7";
  int    checks = 0;
  int    errors = 0;

  // sequence-level model
  int m_pos, m_fails, m_lock_left;
  bit m_done, m_locked, m_ok, m_miss;

  unlock_sequencer #(
    .SEQ_LEN(SEQ_LEN), .POS_W(5), .FAIL_W(8), .MAX_FAILS(MAX_F), .LOCKOUT_CYCLES(LOCK_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .unlock(unlock), .key_clear(key_clear), .pos(pos), .match_ok(match_ok),
    .mismatch(mismatch), .done(done), .locked(locked), .fail_cnt(fail_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_fails = 0; m_lock_left = 0;
    m_done = 1'b0; m_locked = 1'b0; m_ok = 1'b0; m_miss = 1'b0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] k, input bit c);
    m_ok = 1'b0;
    m_miss = 1'b0;
    if (m_locked) begin
      m_lock_left--;
      if (m_lock_left == 0) begin
        m_locked = 1'b0; m_fails = 0; m_pos = 0;
      end
    end else if (c) begin
      m_pos = 0;
      m_done = 1'b0;
    end else if (v && !m_done) begin
      if (k == pw[m_pos]) begin
        m_ok = 1'b1;
        if (m_pos == SEQ_LEN - 1) begin
          m_done = 1'b1; m_fails = 0;
        end else begin
          m_pos++;
        end
      end else begin
        m_miss = 1'b1;
        m_pos = 0;
        if (m_fails < 255) m_fails++;
        if (LOCK_EN && m_fails == MAX_F) begin
          m_locked = 1'b1;
          m_lock_left = LOCK_CYC;
        end
      end
    end
  endtask

  // one clock with the given inputs; the comparator output follows the key byte
  task automatic cyc(input bit v, input logic [7:0] k, input bit c);
    key_valid = v;
    key_clear = c;
    for (int i = 0; i < SEQ_LEN; i++) unlock[i] = (k == pw[i]);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(v, k, c);
    #1;
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("pos", int'(pos), m_pos);
    chk("fail_cnt", int'(fail_cnt), m_fails);
    chk("match_ok", int'(match_ok), int'(m_ok));
    chk("mismatch", int'(mismatch), int'(m_miss));
    chk("done", int'(done), int'(m_done));
    chk("locked", int'(locked), int'(m_locked));
    chk("key_ready", int'(key_ready), int'(!m_done && !m_locked && !key_clear));
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_clear = 1'b0;
    unlock = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 8'd0, 1'b0);

    // T1: full sequence, one byte per cycle
    for (int i = 0; i < SEQ_LEN; i++) cyc(1'b1, pw[i], 1'b0);
    chk("t1_done", int'(done), 1);
    chk("t1_pos", int'(pos), 18);
    chk("t1_match", int'(match_ok), 1);
    cyc(1'b1, 8'd83, 1'b0);
    chk("t1_ready_done", int'(key_ready), 0);
    chk("t1_no_pulse", int'(match_ok), 0);
    // T3b: clear out of DONE
    cyc(1'b0, 8'd0, 1'b1);
    chk("t3_done_clr", int'(done), 0);
    cyc(1'b0, 8'd0, 1'b0);

    // T2: miss on the third byte, then restart
    cyc(1'b1, 8'd83, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    cyc(1'b1, 8'd52, 1'b0);
    cyc(1'b1, 8'd0, 1'b0);
    chk("t2_mismatch", int'(mismatch), 1);
    chk("t2_pos0", int'(pos), 0);
    chk("t2_fail1", int'(fail_cnt), 1);
    cyc(1'b1, 8'd83, 1'b0);
    chk("t2_pos1", int'(pos), 1);
    // missed 'S' at position 1 is not retried as position 0
    cyc(1'b1, 8'd83, 1'b0);
    chk("t2_discard_pos", int'(pos), 0);
    chk("t2_fail2", int'(fail_cnt), 2);
    // repeated '_' sets several unlock bits; only the current one counts
    for (int i = 0; i < 3; i++) cyc(1'b1, pw[i], 1'b0);
    cyc(1'b1, 8'd95, 1'b0);
    chk("t2_repeat_pos", int'(pos), 4);

    // T3: clear wins over valid at pos 5
    cyc(1'b1, pw[4], 1'b0);
    chk("t3_pos5", int'(pos), 5);
    cyc(1'b1, pw[5], 1'b1);
    chk("t3_clr_pos", int'(pos), 0);
    chk("t3_clr_nopulse", int'(match_ok), 0);
    chk("t3_clr_fail", int'(fail_cnt), 2);
    for (int i = 0; i < SEQ_LEN; i++) cyc(1'b1, pw[i], 1'b0);
    chk("t3_fail_cleared", int'(fail_cnt), 0);
    cyc(1'b0, 8'd0, 1'b1);

    // T6: async reset at pos 7
    cyc(1'b1, 8'd0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, pw[i], 1'b0);
    chk("t6_pre_pos", int'(pos), 7);
    rst_n = 1'b0;
    #1;
    chk("t6_pos", int'(pos), 0);
    chk("t6_fail", int'(fail_cnt), 0);
    chk("t6_match", int'(match_ok), 0);
    chk("t6_done", int'(done), 0);
    model_reset();
    cyc(1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 8'd0, 1'b0);

`ifdef UNLOCK_SEQ_LOCKOUT_EN
    // T4: three misses lock the block for LOCK_CYC cycles
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'd0, 1'b0);
    chk("t4_locked", int'(locked), 1);
    chk("t4_fail3", int'(fail_cnt), 3);
    for (int i = 0; i < LOCK_CYC - 1; i++) cyc(1'b1, pw[0], 1'b1);
    chk("t4_still_locked", int'(locked), 1);
    cyc(1'b1, pw[0], 1'b1);
    chk("t4_unlocked", int'(locked), 0);
    chk("t4_fail0", int'(fail_cnt), 0);
    chk("t4_pos0", int'(pos), 0);
    cyc(1'b1, pw[0], 1'b0);
    chk("t4_resume", int'(pos), 1);
    // T6b: async reset while locked
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    chk("t6b_locked", int'(locked), 1);
    rst_n = 1'b0;
    #1;
    chk("t6b_unlocked", int'(locked), 0);
    chk("t6b_fail", int'(fail_cnt), 0);
    model_reset();
    cyc(1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 8'd0, 1'b0);
`else
    // T5: fail counter saturates, never locks
    for (int i = 0; i < 300; i++) cyc(1'b1, 8'd0, 1'b0);
    chk("t5_sat", int'(fail_cnt), 255);
    chk("t5_locked", int'(locked), 0);
    chk("t5_ready", int'(key_ready), 1);
`endif

    cyc(1'b0, 8'd0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
